reset_controller: RTL and testbench

//   Consumer end of the watchdog reset request. Samples the watchdog's WDT_output pulse, stretches
//   it into a clean system reset for the CPU core, and records the reset cause in a status register

---
 rtl/reset_controller_if.sv | 19 +
 rtl/reset_controller.sv | 135 +++++++++++++
 tb/tb_reset_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_controller_if.sv
// IO bus bundle for the reset controller: chip select, register address, strobes and data.
interface reset_controller_if;
   logic        rstCtrl;
   logic [1:0]  address;
   logic        read_enable;
   logic        write_enable;
   logic [15:0] write_data_in;
   logic [15:0] read_data_out;

   modport master (
      output rstCtrl, address, read_enable, write_enable, write_data_in,
      input  read_data_out
   );

   modport slave (
      input  rstCtrl, address, read_enable, write_enable, write_data_in,
      output read_data_out
   );
endinterface

// File: rtl/reset_controller.sv
// Stretches watchdog reset requests into a clean sys_reset and records the reset cause in STATUS.
// Define RSTCTRL_SW_RESET_EN to enable the software reset (write SW_KEY to CTRL).
module reset_controller #(
   parameter int unsigned HOLD_CYCLES  = 8,
   parameter int unsigned GUARD_CYCLES = 16,
   parameter logic [15:0] SW_KEY       = 16'hA5A5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               wdt_reset_req,
   reset_controller_if.slave  bus,
   output logic               sys_reset
);

   typedef enum logic [1:0] {StRun, StHold, StGuard} state_e;

   localparam logic [7:0] HoldInit  = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GuardInit = 8'(GUARD_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic        sys_reset_q, sys_reset_d;
   logic        wdt_req_q;
   logic [2:0]  cause_q, cause_d;
   logic [7:0]  wdt_count_q, wdt_count_d;

   logic        is_status;
   logic        status_wr;
   logic        ctrl_key_wr;
   logic        wdt_edge;
   logic        sw_trig;
   logic        accept;
   logic [15:0] status;

   assign is_status   = (bus.address == 2'd2);
   assign status_wr   = bus.rstCtrl & bus.write_enable & is_status;
   assign ctrl_key_wr = bus.rstCtrl & bus.write_enable & ~is_status &
                        (bus.write_data_in == SW_KEY);
   assign wdt_edge    = wdt_reset_req & ~wdt_req_q;

`ifdef RSTCTRL_SW_RESET_EN
   assign sw_trig = ctrl_key_wr;
`else
   logic unused_ctrl_key_wr;
   assign unused_ctrl_key_wr = ctrl_key_wr;
   assign sw_trig            = 1'b0;
`endif

   // Only requests seen while running count; HOLD/GUARD drop them entirely.
   assign accept = (state_q == StRun) & (wdt_edge | sw_trig);

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      sys_reset_d = sys_reset_q;
      unique case (state_q)
         StRun: begin
            sys_reset_d = 1'b0;
            if (wdt_edge | sw_trig) begin
               state_d     = StHold;
               hold_cnt_d  = HoldInit;
               sys_reset_d = 1'b1;
            end
         end
         StHold: begin
            sys_reset_d = 1'b1;
            if (hold_cnt_q != 8'd0) begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end else begin
               state_d     = StGuard;
               hold_cnt_d  = GuardInit;
               sys_reset_d = 1'b0;
            end
         end
         StGuard: begin
            sys_reset_d = 1'b0;
            if (hold_cnt_q != 8'd0) begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end else begin
               state_d = StRun;
            end
         end
         default: begin
            state_d     = StRun;
            sys_reset_d = 1'b0;
         end
      endcase
   end

   // Clears are applied first so a same-cycle cause set wins.
   always_comb begin
      cause_d     = cause_q;
      wdt_count_d = wdt_count_q;
      if (status_wr) begin
         cause_d = cause_q & ~bus.write_data_in[2:0];
         if (bus.write_data_in[8]) begin
            wdt_count_d = 8'd0;
         end
      end
      if (accept) begin
         if (wdt_edge) begin
            cause_d[0] = 1'b1;
            if (wdt_count_d != 8'hFF) begin
               wdt_count_d = wdt_count_d + 8'd1;
            end
         end
         if (sw_trig) begin
            cause_d[1] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StHold;
         hold_cnt_q  <= HoldInit;
         sys_reset_q <= 1'b1;
         wdt_req_q   <= 1'b0;
         cause_q     <= 3'b100;
         wdt_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         sys_reset_q <= sys_reset_d;
         wdt_req_q   <= wdt_reset_req;
         cause_q     <= cause_d;
         wdt_count_q <= wdt_count_d;
      end
   end

   assign status            = {wdt_count_q, 5'b00000, cause_q};
   assign bus.read_data_out = (bus.rstCtrl & bus.read_enable & is_status) ? status : 16'h0000;
   assign sys_reset         = sys_reset_q;

endmodule

// File: tb/tb_reset_controller.sv
// Scoreboard bench for reset_controller: stimulus queues expected reads and sys_reset pulses,
// a negedge monitor pops and compares them. Honours RSTCTRL_SW_RESET_EN like the design.
module tb_reset_controller;

   typedef struct {
      int start;
      int len;
   } pulse_t;

   logic clock;
   logic reset;
   logic wdt_reset_req;
   logic sys_reset;

   reset_controller_if bus_if ();

   reset_controller dut (
      .clock         (clock),
      .reset         (reset),
      .wdt_reset_req (wdt_reset_req),
      .bus           (bus_if.slave),
      .sys_reset     (sys_reset)
   );

   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] rd_q[$];
   pulse_t      pulse_q[$];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: compares reads and completed sys_reset pulses against the queues.
   initial begin
      bit          in_pulse;
      int          rise;
      int          len;
      logic [15:0] exp_rd;
      pulse_t      exp_p;
      in_pulse = 1'b0;
      rise     = 0;
      len      = 0;
      forever begin
         @(negedge clock);
         if (bus_if.rstCtrl && bus_if.read_enable) begin
            checks++;
            if (rd_q.size() == 0) begin
               failures++;
               $display("FAIL read_unexpected: got %h, no read expected", bus_if.read_data_out);
            end else begin
               exp_rd = rd_q.pop_front();
               if (bus_if.read_data_out !== exp_rd) begin
                  failures++;
                  $display("FAIL read_data cyc=%0d: got %h, expected %h",
                           cyc, bus_if.read_data_out, exp_rd);
               end
            end
         end else begin
            checks++;
            if (bus_if.read_data_out !== 16'h0000) begin
               failures++;
               $display("FAIL read_idle cyc=%0d: got %h, expected 0000", cyc, bus_if.read_data_out);
            end
         end
         if (sys_reset === 1'b1) begin
            if (!in_pulse) begin
               in_pulse = 1'b1;
               rise     = cyc;
               len      = 0;
            end
            len++;
         end else if (in_pulse) begin
            in_pulse = 1'b0;
            checks++;
            if (pulse_q.size() == 0) begin
               failures++;
               $display("FAIL pulse_unexpected: start=%0d len=%0d, no pulse expected", rise, len);
            end else begin
               exp_p = pulse_q.pop_front();
               if (rise != exp_p.start || len != exp_p.len) begin
                  failures++;
                  $display("FAIL pulse_shape: got start=%0d len=%0d, expected start=%0d len=%0d",
                           rise, len, exp_p.start, exp_p.len);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within the time limit");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic expect_pulse(input int start, input int len);
      pulse_t p;
      p.start = start;
      p.len   = len;
      pulse_q.push_back(p);
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [15:0] data);
      bus_if.rstCtrl       = 1'b1;
      bus_if.write_enable  = 1'b1;
      bus_if.address       = addr;
      bus_if.write_data_in = data;
      tick(1);
      bus_if.rstCtrl       = 1'b0;
      bus_if.write_enable  = 1'b0;
      bus_if.write_data_in = 16'h0000;
   endtask

   task automatic bus_read(input logic [1:0] addr, input logic [15:0] exp);
      rd_q.push_back(exp);
      bus_if.rstCtrl     = 1'b1;
      bus_if.read_enable = 1'b1;
      bus_if.address     = addr;
      tick(1);
      bus_if.rstCtrl     = 1'b0;
      bus_if.read_enable = 1'b0;
   endtask

   // One 4-cycle watchdog pulse; the DUT samples its rising edge at the next clock.
   task automatic wdt_event(input bit accepted);
      if (accepted) expect_pulse(cyc + 1, 8);
      wdt_reset_req = 1'b1;
      tick(4);
      wdt_reset_req = 1'b0;
   endtask

   initial begin
      int s;
      reset                = 1'b1;
      wdt_reset_req        = 1'b0;
      bus_if.rstCtrl       = 1'b0;
      bus_if.address       = 2'd0;
      bus_if.read_enable   = 1'b0;
      bus_if.write_enable  = 1'b0;
      bus_if.write_data_in = 16'h0000;

      // T1: power-on reset for one cycle
      expect_pulse(1, 8);
      tick(1);
      reset = 1'b0;
      tick(30);
      bus_read(2'd2, 16'h0004);
      bus_read(2'd0, 16'h0000);
      bus_read(2'd3, 16'h0000);

      // T2: clear STATUS, then one watchdog event
      bus_write(2'd2, 16'h0107);
      bus_read(2'd2, 16'h0000);
      s = cyc + 1;
      wdt_event(1'b1);
      // T3: second pulse 5 cycles after sys_reset falls lands in GUARD
      while (cyc < s + 13) tick(1);
      wdt_event(1'b0);
      tick(30);
      bus_read(2'd2, 16'h0101);

      // T6a: watchdog edge and a cause clear in the same cycle
      expect_pulse(cyc + 1, 8);
      wdt_reset_req        = 1'b1;
      bus_if.rstCtrl       = 1'b1;
      bus_if.write_enable  = 1'b1;
      bus_if.address       = 2'd2;
      bus_if.write_data_in = 16'h0007;
      tick(1);
      bus_if.rstCtrl       = 1'b0;
      bus_if.write_enable  = 1'b0;
      tick(3);
      wdt_reset_req = 1'b0;
      tick(30);
      bus_read(2'd2, 16'h0201);

      // T5: software reset via CTRL
`ifdef RSTCTRL_SW_RESET_EN
      expect_pulse(cyc + 1, 8);
      bus_write(2'd0, 16'hA5A5);
      tick(30);
      bus_read(2'd2, 16'h0203);
      bus_write(2'd0, 16'h1234);
      tick(30);
      bus_read(2'd2, 16'h0203);
`else
      bus_write(2'd0, 16'hA5A5);
      tick(30);
      bus_read(2'd2, 16'h0201);
`endif

      // T4: count saturation
      bus_write(2'd2, 16'h0107);
      bus_read(2'd2, 16'h0000);
      for (int i = 0; i < 255; i++) begin
         wdt_event(1'b1);
         tick(24);
      end
      bus_read(2'd2, 16'hFF01);
      wdt_event(1'b1);
      tick(24);
      bus_read(2'd2, 16'hFF01);
      bus_write(2'd2, 16'h0100);
      bus_read(2'd2, 16'h0001);

      // T6b: board reset mid-HOLD restarts the full hold
      s = cyc + 1;
      expect_pulse(s, 11);
      wdt_reset_req = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(1);
      reset         = 1'b0;
      wdt_reset_req = 1'b0;
      tick(30);
      bus_read(2'd2, 16'h0004);

      tick(5);
      checks++;
      if (pulse_q.size() != 0) begin
         failures++;
         $display("FAIL pulse_missing: got %0d outstanding, expected 0", pulse_q.size());
      end
      checks++;
      if (rd_q.size() != 0) begin
         failures++;
         $display("FAIL read_missing: got %0d outstanding, expected 0", rd_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
